// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul flag collector: sizing, FSM states,
// cell indexing and dimension clamping.
package matmul_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BUS_WIDTH  = 64;
    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned N_CELLS    = MAX_DIM * MAX_DIM;
    localparam int unsigned DIM_W      = $clog2(MAX_DIM + 1);
    localparam int unsigned CNT_W      = $clog2(N_CELLS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Bit position of result cell (r,c) in the flag vector.
    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c);
        return r * MAX_DIM + c;
    endfunction

    // A zero dimension means one; anything beyond the array size saturates.
    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        if (d == '0) begin
            return DIM_W'(1);
        end else if (d > DIM_W'(MAX_DIM)) begin
            return DIM_W'(MAX_DIM);
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/matmul_flag_collector_popcount.sv
// Combinational population count of the committed flag vector.
module flag_popcount #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            count_o = count_o + W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/matmul_flag_collector.sv
// Collects per-cell MAC overflow pulses into a sticky, dimension-masked vector
// and commits it to the flags register with a one-cycle write/done pulse.
module matmul_flag_collector
    import matmul_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [DIM_W-1:0]   dim_n_i,
    input  logic [DIM_W-1:0]   dim_m_i,
    input  logic [DIM_W-1:0]   dim_k_i,
    input  logic               step_valid_i,
    input  logic [N_CELLS-1:0] cell_ovf_i,
    output logic               busy_o,
    output logic               flags_we_o,
    output logic [N_CELLS-1:0] flags_data_o,
    output logic [CNT_W-1:0]   ovf_count_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CELLS-1:0] sticky_q, sticky_d;
    logic [DIM_W-1:0]   dim_n_q, dim_n_d;
    logic [DIM_W-1:0]   dim_m_q, dim_m_d;
    logic [DIM_W-1:0]   dim_k_q, dim_k_d;
    logic [N_CELLS-1:0] mask;
    logic [CNT_W-1:0]   cnt_inc;

    // Cells outside the active N x M window can never raise a flag.
    for (genvar r = 0; r < int'(MAX_DIM); r++) begin : g_row
        for (genvar c = 0; c < int'(MAX_DIM); c++) begin : g_col
            assign mask[cell_idx(r, c)] = (DIM_W'(r) < dim_n_q) && (DIM_W'(c) < dim_m_q);
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dim_n_d  = dim_n_q;
        dim_m_d  = dim_m_q;
        dim_k_d  = dim_k_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dim_n_d  = clamp_dim(dim_n_i);
                    dim_m_d  = clamp_dim(dim_m_i);
                    dim_k_d  = clamp_dim(dim_k_i);
                    sticky_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (step_valid_i) begin
                    sticky_d = sticky_q | (cell_ovf_i & mask);
                    cnt_d    = cnt_inc;
                    if (cnt_inc == CNT_W'(dim_k_q)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sticky_q <= '0;
            dim_n_q  <= '0;
            dim_m_q  <= '0;
            dim_k_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dim_n_q  <= dim_n_d;
            dim_m_q  <= dim_m_d;
            dim_k_q  <= dim_k_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign flags_we_o   = (state_q == COMMIT);
    assign done_o       = (state_q == COMMIT);
    assign flags_data_o = sticky_q;

    flag_popcount #(
        .N (N_CELLS),
        .W (CNT_W)
    ) u_popcount (
        .bits_i  (sticky_q),
        .count_o (ovf_count_o)
    );

endmodule

// File: tb/tb_matmul_flag_collector.sv
// Directed bench for matmul_flag_collector with a cell-level reference model
// compared every cycle, plus literal expectations at the key cycles.
module tb_matmul_flag_collector;
    import matmul_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [DIM_W-1:0]   dn, dm, dk;
    logic               sv;
    logic [N_CELLS-1:0] ovf;
    logic               busy, we, done;
    logic [N_CELLS-1:0] data;
    logic [CNT_W-1:0]   cnt;

    int n_cmp = 0;
    int n_err = 0;

    matmul_flag_collector dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .dim_n_i      (dn),
        .dim_m_i      (dm),
        .dim_k_i      (dk),
        .step_valid_i (sv),
        .cell_ovf_i   (ovf),
        .busy_o       (busy),
        .flags_we_o   (we),
        .flags_data_o (data),
        .ovf_count_o  (cnt),
        .done_o       (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a matrix of flags, an op-in-progress bit, a step tally
    // and a one-cycle "committing" bit.
    int m_n = 0, m_m = 0, m_k = 0, m_steps = 0;
    bit m_running = 0, m_commit = 0;
    bit m_flag [2][2];

    function automatic int clampd(input int v);
        if (v == 0) return 1;
        if (v > 2) return 2;
        return v;
    endfunction

    function automatic int model_word();
        int w = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (m_flag[r][c]) w += (1 << (r * 2 + c));
        return w;
    endfunction

    function automatic int model_count();
        int s = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                s += int'(m_flag[r][c]);
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running = 0; m_commit = 0; m_steps = 0;
            m_n = 0; m_m = 0; m_k = 0;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    m_flag[r][c] = 0;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (!m_running) begin
            if (start) begin
                m_n = clampd(int'(dn)); m_m = clampd(int'(dm)); m_k = clampd(int'(dk));
                m_steps = 0; m_running = 1;
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        m_flag[r][c] = 0;
            end
        end else if (sv) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    if (ovf[r * 2 + c] && r < m_n && c < m_m) m_flag[r][c] = 1;
            m_steps++;
            if (m_steps == m_k) begin
                m_running = 0;
                m_commit  = 1;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_running || m_commit));
        chk("we",   int'(we),   int'(m_commit));
        chk("done", int'(done), int'(m_commit));
        chk("data", int'(data), model_word());
        chk("count", int'(cnt), model_count());
    end

    // driver tasks
    task automatic cyc(input bit st, input int n, input int m, input int k,
                       input bit step, input int pulses);
        start = st; dn = DIM_W'(n); dm = DIM_W'(m); dk = DIM_W'(k);
        sv = step; ovf = N_CELLS'(pulses);
        @(posedge clk);
        #1;
        start = 0; sv = 0; ovf = '0; dn = '0; dm = '0; dk = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit(input string name, input bit e_busy, input bit e_we, input int e_data,
                       input int e_cnt);
        chk({name, ".busy"}, int'(busy), int'(e_busy));
        chk({name, ".we"},   int'(we),   int'(e_we));
        chk({name, ".done"}, int'(done), int'(e_we));
        chk({name, ".data"}, int'(data), e_data);
        chk({name, ".count"}, int'(cnt), e_cnt);
    endtask

    initial begin
        rst_n = 1; start = 0; sv = 0; ovf = '0; dn = '0; dm = '0; dk = '0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0, 0);
        rst_n = 1;
        idle(1);

        // 1: full size, single overflow
        cyc(1, 2, 2, 2, 0, 0);
        lit("t1_run", 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b0001);
        lit("t1_step1", 1, 0, 4'b0001, 1);
        cyc(0, 0, 0, 0, 1, 4'b0000);
        lit("t1_commit", 1, 1, 4'b0001, 1);
        idle(1);
        lit("t1_after", 0, 0, 4'b0001, 1);

        // 2: mask to one row
        cyc(1, 1, 2, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b1111);
        lit("t2_commit", 1, 1, 4'b0011, 2);
        idle(1);

        // 3: sticky OR, then steps ignored in IDLE
        cyc(1, 2, 2, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b0100);
        cyc(0, 0, 0, 0, 1, 4'b0100);
        lit("t3_commit", 1, 1, 4'b0100, 1);
        idle(1);
        cyc(0, 0, 0, 0, 1, 4'b1111);
        lit("t3_idle_step", 0, 0, 4'b0100, 1);
        idle(1);

        // 4: clamping (0,0,3 -> 1,1,2) and stalls between steps
        cyc(1, 0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            lit("t4_stall", 1, 0, 4'b0001, 1);
        end
        cyc(0, 0, 0, 0, 1, 4'b0000);
        lit("t4_commit", 1, 1, 4'b0001, 1);
        idle(1);

        // 5a: start while busy is ignored; op keeps its own 2x2, k=2
        cyc(1, 2, 2, 2, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b0010);
        lit("t5_busy_start", 1, 0, 4'b0010, 1);
        cyc(0, 0, 0, 0, 1, 4'b1000);
        lit("t5_commit", 1, 1, 4'b1010, 2);
        idle(1);

        // 5b: reset mid-operation aborts silently
        cyc(1, 2, 2, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b0001);
        rst_n = 0;
        @(posedge clk);
        #1;
        lit("t5_in_reset", 0, 0, 0, 0);
        rst_n = 1;
        idle(2);
        lit("t5_after_reset", 0, 0, 0, 0);

        // 5c: normal op after reset; column mask keeps cells 0 and 2
        cyc(1, 2, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b1111);
        lit("t5_restart", 1, 1, 4'b0101, 2);
        idle(1);

        // 6: every cell flagged, count at its maximum
        cyc(1, 2, 2, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b1111);
        lit("t6_full", 1, 1, 4'b1111, 4);
        idle(2);
        lit("t6_hold", 0, 0, 4'b1111, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
